// File: rtl/prog_clk_div_if.sv
// Divisor configuration bus for prog_clk_div.
//   cfg_valid : write request (master -> slave)
//   cfg_ready : slave can accept a write for cfg_ch this cycle
//   cfg_ch    : target channel index
//   cfg_div   : new terminal count (period = cfg_div + 1 cycles)
interface prog_clk_div_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 26
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..div while its run bit is high; at terminal count it
// emits a one-cycle tick and toggles a 50% duty clk_en level. New divisors are
// written into a per-channel shadow and only take effect at a period boundary
// (terminal count) or while the channel is stopped, so periods are never cut.
//
// Ports:
//   clk     : clock, all logic on posedge
//   reset   : synchronous active-high reset
//   run     : per-channel enable (1 = count, 0 = stopped, counter cleared)
//   sync    : (only with PROG_CLK_DIV_SYNC_EN) restart all channels in phase
//   cfg     : divisor write bus (prog_clk_div_if.slave)
//   tick    : registered one-cycle strobe per channel at terminal count
//   clk_en  : registered level per channel, toggles at terminal count
//
// Build option: define PROG_CLK_DIV_SYNC_EN to add the sync input.
module prog_clk_div #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 49999999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   run,
`ifdef PROG_CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  prog_clk_div_if.slave    cfg,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_en
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] DivRst = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q    [NCH];
  logic [WIDTH-1:0] cnt_d    [NCH];
  logic [WIDTH-1:0] div_q    [NCH];
  logic [WIDTH-1:0] div_d    [NCH];
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic [NCH-1:0]   clk_en_q, clk_en_d;

  logic [NCH-1:0]   cfg_hit;  // one-hot decode of cfg_ch; all zero when out of range
  logic [NCH-1:0]   apply;    // shadow -> div transfer this edge
  logic             cfg_accept;

  always_comb begin
    cfg_hit = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (cfg.cfg_ch == CHW'(i)) cfg_hit[i] = 1'b1;
    end
  end

  // Out-of-range channels never hit, so they read as ready and the write is dropped.
  assign cfg.cfg_ready = ~|(cfg_hit & pending_q);
  assign cfg_accept    = cfg.cfg_valid & cfg.cfg_ready;

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    tick_d    = tick_q;
    clk_en_d  = clk_en_q;
    apply     = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (run[i]) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i]    = '0;
          tick_d[i]   = 1'b1;
          clk_en_d[i] = ~clk_en_q[i];
          apply[i]    = pending_q[i];
        end else begin
          cnt_d[i]  = cnt_q[i] + WIDTH'(1);
          tick_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        apply[i]  = pending_q[i];
      end
`ifdef PROG_CLK_DIV_SYNC_EN
      if (sync) begin
        cnt_d[i]    = '0;
        tick_d[i]   = 1'b0;
        clk_en_d[i] = 1'b0;
        apply[i]    = pending_q[i];
      end
`endif
      if (apply[i]) begin
        div_d[i]     = shadow_q[i];
        pending_d[i] = 1'b0;
      end
      // A hit requires pending_q[i] == 0, so this never collides with apply[i].
      if (cfg_accept && cfg_hit[i]) begin
        shadow_d[i]  = cfg.cfg_div;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i]    <= '0;
        div_q[i]    <= DivRst;
        shadow_q[i] <= DivRst;
      end
      pending_q <= '0;
      tick_q    <= '0;
      clk_en_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign tick   = tick_q;
  assign clk_en = clk_en_q;

endmodule

// File: tb/tb_prog_clk_div.sv
module tb_prog_clk_div;
  localparam int unsigned NCH   = 3;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEF   = 9;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] run;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_en;
`ifdef PROG_CLK_DIV_SYNC_EN
  logic           sync;
`endif

  prog_clk_div_if #(.NCH(NCH), .WIDTH(WIDTH)) cfg_bus ();

  prog_clk_div #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
`ifdef PROG_CLK_DIV_SYNC_EN
    .sync   (sync),
`endif
    .cfg    (cfg_bus),
    .tick   (tick),
    .clk_en (clk_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Directed per-cycle vectors: inputs, cfg_ready before the edge, outputs after it.
  typedef struct {
    logic             rst;
    logic [NCH-1:0]   run;
    logic             vld;
    logic [1:0]       ch;
    logic [WIDTH-1:0] div;
    logic             rdy;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_en;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic [NCH-1:0] r, input logic v,
                              input logic [1:0] ch, input logic [WIDTH-1:0] d,
                              input logic rdy, input logic [NCH-1:0] t,
                              input logic [NCH-1:0] ce);
    vec_t e;
    e.rst = rst; e.run = r; e.vld = v; e.ch = ch; e.div = d;
    e.rdy = rdy; e.tick = t; e.clk_en = ce;
    tbl.push_back(e);
  endfunction

  // Behavioural model: cycles elapsed in the current period versus period length.
  int age [NCH];
  int per [NCH];
  int nxt [NCH];   // queued period length, -1 when nothing is queued
  logic [NCH-1:0] m_tick, m_clk;

  function automatic logic model_ready(input int ch);
    if (ch >= int'(NCH)) return 1'b1;
    return nxt[ch] < 0;
  endfunction

  task automatic model_step();
    logic acc;
    if (reset) begin
      for (int i = 0; i < int'(NCH); i++) begin
        age[i] = 0; per[i] = DEF + 1; nxt[i] = -1;
      end
      m_tick = '0; m_clk = '0;
      return;
    end
    acc = cfg_bus.cfg_valid && model_ready(int'(cfg_bus.cfg_ch));
    for (int i = 0; i < int'(NCH); i++) begin
      logic sw;
      sw = 1'b0;
      if (run[i]) begin
        age[i]++;
        if (age[i] == per[i]) begin
          age[i] = 0; m_tick[i] = 1'b1; m_clk[i] = ~m_clk[i]; sw = 1'b1;
        end else begin
          m_tick[i] = 1'b0;
        end
      end else begin
        age[i] = 0; m_tick[i] = 1'b0; sw = 1'b1;
      end
`ifdef PROG_CLK_DIV_SYNC_EN
      if (sync) begin
        age[i] = 0; m_tick[i] = 1'b0; m_clk[i] = 1'b0; sw = 1'b1;
      end
`endif
      if (sw && nxt[i] >= 0) begin
        per[i] = nxt[i]; nxt[i] = -1;
      end
    end
    if (acc && int'(cfg_bus.cfg_ch) < int'(NCH))
      nxt[int'(cfg_bus.cfg_ch)] = int'(cfg_bus.cfg_div) + 1;
  endtask

  task automatic drive(input logic rst, input logic [NCH-1:0] r, input logic v,
                       input logic [1:0] ch, input logic [WIDTH-1:0] d);
    reset = rst; run = r; cfg_bus.cfg_valid = v; cfg_bus.cfg_ch = ch; cfg_bus.cfg_div = d;
  endtask

  task automatic edge_idle();
    @(posedge clk); #1;
    cfg_bus.cfg_valid = 1'b0;
  endtask

  initial begin
    drive(1'b1, '0, 1'b0, 2'd0, '0);
`ifdef PROG_CLK_DIV_SYNC_EN
    sync = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;

    // Reset with a write that must be dropped, then REQ-031 style count with div 9.
    add(1, 3'b000, 1, 0, 2, 1, 3'b000, 3'b000);
    add(0, 3'b000, 0, 0, 0, 1, 3'b000, 3'b000);
    for (int k = 1; k <= 40; k++)
      add(0, 3'b001, 0, 0, 0, 1, (k % 10 == 0) ? 3'b001 : 3'b000,
          ((k / 10) % 2 != 0) ? 3'b001 : 3'b000);
    // ch0 div 3, then write 7 mid-period: current period finishes, then period 8.
    add(0, 3'b000, 1, 0, 3, 1, 3'b000, 3'b000);
    add(0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000);
    for (int k = 1; k <= 5; k++)
      add(0, 3'b001, 0, 0, 0, 1, (k == 4) ? 3'b001 : 3'b000, (k >= 4) ? 3'b001 : 3'b000);
    add(0, 3'b001, 1, 0, 7, 1, 3'b000, 3'b001);
    add(0, 3'b001, 0, 1, 0, 1, 3'b000, 3'b001);
    add(0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b000);
    for (int k = 9; k <= 17; k++)
      add(0, 3'b001, 0, 0, 0, 1, (k == 16) ? 3'b001 : 3'b000, (k >= 16) ? 3'b001 : 3'b000);
    // ch1 div 0: tick stuck high, clk_en toggles every cycle, freezes on stop.
    add(0, 3'b000, 1, 1, 0, 1, 3'b000, 3'b001);
    add(0, 3'b000, 0, 1, 0, 0, 3'b000, 3'b001);
    for (int j = 1; j <= 3; j++)
      add(0, 3'b010, 0, 1, 0, 1, 3'b010, (j % 2 != 0) ? 3'b011 : 3'b001);
    for (int j = 1; j <= 2; j++)
      add(0, 3'b000, 0, 1, 0, 1, 3'b000, 3'b011);
    // Stopped ch2 takes div 4 on the next edge; out-of-range write is ignored.
    add(0, 3'b000, 1, 2, 4, 1, 3'b000, 3'b011);
    add(0, 3'b000, 0, 2, 0, 0, 3'b000, 3'b011);
    add(0, 3'b000, 0, 2, 0, 1, 3'b000, 3'b011);
    for (int k = 1; k <= 6; k++)
      add(0, 3'b100, (k == 2), (k == 2) ? 2'd3 : 2'd2, 1, 1,
          (k == 5) ? 3'b100 : 3'b000, (k >= 5) ? 3'b111 : 3'b011);
    // Reset mid-period with a pending write: everything back to DEFAULT_DIV.
    add(1, 3'b000, 0, 0, 0, 1, 3'b000, 3'b000);
    for (int k = 1; k <= 5; k++)
      add(0, 3'b001, 0, 0, 0, 1, 3'b000, 3'b000);
    add(0, 3'b001, 1, 0, 2, 1, 3'b000, 3'b000);
    add(1, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);
    for (int k = 1; k <= 10; k++)
      add(0, 3'b001, 0, 0, 0, 1, (k == 10) ? 3'b001 : 3'b000, (k == 10) ? 3'b001 : 3'b000);

    foreach (tbl[n]) begin
      drive(tbl[n].rst, tbl[n].run, tbl[n].vld, tbl[n].ch, tbl[n].div);
      #1;
      chk("vec_ready", n, 32'(cfg_bus.cfg_ready), 32'(tbl[n].rdy));
      @(posedge clk); #1;
      chk("vec_tick", n, 32'(tick), 32'(tbl[n].tick));
      chk("vec_clk_en", n, 32'(clk_en), 32'(tbl[n].clk_en));
      cfg_bus.cfg_valid = 1'b0;
    end

`ifdef PROG_CLK_DIV_SYNC_EN
    // ch0 div 3 and ch1 div 5 started out of phase, then realigned by sync.
    drive(1, 3'b000, 0, 0, 0); edge_idle();
    drive(0, 3'b000, 1, 0, 3); edge_idle();
    drive(0, 3'b000, 1, 1, 5); edge_idle();
    drive(0, 3'b000, 0, 0, 0); edge_idle();
    run = 3'b001; repeat (2) edge_idle();
    run = 3'b011; repeat (3) edge_idle();
    sync = 1'b1; drive(0, 3'b011, 1, 2, 1);
    @(posedge clk); #1;
    sync = 1'b0; cfg_bus.cfg_valid = 1'b0;
    chk("sync_tick", 0, 32'(tick), 32'd0);
    chk("sync_clk_en", 0, 32'(clk_en), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      cfg_bus.cfg_ch = 2'd2;
      #1;
      if (k == 1) chk("sync_cfg_pending", k, 32'(cfg_bus.cfg_ready), 32'd0);
      @(posedge clk); #1;
      chk("sync_tick0", k, 32'(tick[0]), (k == 4) ? 32'd1 : 32'd0);
      chk("sync_tick1", k, 32'(tick[1]), (k == 6) ? 32'd1 : 32'd0);
    end
`endif

    // Randomized traffic against the model.
    drive(1, '1, 0, 0, 0);
    @(posedge clk); model_step(); #1;
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < int'(NCH); i++)
        if ($urandom_range(0, 15) == 0) run[i] = ~run[i];
      cfg_bus.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_bus.cfg_ch    = 2'($urandom_range(0, 3));
      cfg_bus.cfg_div   = WIDTH'($urandom_range(0, 6));
`ifdef PROG_CLK_DIV_SYNC_EN
      sync = ($urandom_range(0, 49) == 0);
`endif
      #1;
      chk("rnd_ready", c, 32'(cfg_bus.cfg_ready), 32'(model_ready(int'(cfg_bus.cfg_ch))));
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_tick", c, 32'(tick), 32'(m_tick));
      chk("rnd_clk_en", c, 32'(clk_en), 32'(m_clk));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
